reg_file_dump_reader: RTL and testbench

Debug-side reader for the processor register file. On request, it freezes the core and walks a contiguous range of register addresses through one asynchronous read port. Each word is streamed out over a valid/ready handshake. It sits beside the register file and drives the read-address mux while the core is stalled, so register contents can be dumped without disturbing architectural state.

---
 rtl/reg_file_dump_reader.sv | 144 ++++++++++++++
 tb/tb_reg_file_dump_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump_reader.sv
// reg_file_dump_reader: debug-side register file dumper.
// Stalls the core, walks a contiguous (wrapping) address range through the
// register file's asynchronous read port and streams each word out over a
// valid/ready handshake.
// Optional build macro: REG_DUMP_CHECKSUM_EN adds dump_sum, the XOR of every
// word accepted during the most recent dump.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; all outputs quiet
// S_STALL | stall_req raised, waiting for the core's stall_ack
// S_READ  | rf_addr=ptr, capture rf_data/ptr into the output registers
// S_SEND  | dump_valid high, holding the word until dump_ready
// S_FIN   | one-cycle done pulse, stall released

module reg_file_dump_reader #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W:0]      count,
    output logic                 stall_req,
    input  logic                 stall_ack,
    output logic [ADDR_W-1:0]    rf_addr,
    input  logic [REG_WIDTH-1:0] rf_data,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [ADDR_W-1:0]    dump_addr,
    output logic [REG_WIDTH-1:0] dump_data,
    output logic                 busy,
`ifdef REG_DUMP_CHECKSUM_EN
    output logic [REG_WIDTH-1:0] dump_sum,
`endif
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STALL = 3'd1,
        S_READ  = 3'd2,
        S_SEND  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(REG_DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W:0]   count_clamped;
    logic              start_ok;
    logic              hs;

    // Requests above the register count just dump the whole file once.
    assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    assign start_ok      = (state == S_IDLE) && start;
    assign hs            = (state == S_SEND) && dump_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx   = state;
        stall_req  = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        rf_addr    = ptr;
        case (state)
            S_IDLE: begin
                busy    = 1'b0;
                rf_addr = '0;
                if (start) state_nx = (count == '0) ? S_FIN : S_STALL;
            end
            S_STALL: begin
                stall_req = 1'b1;
                if (stall_ack) state_nx = S_READ;
            end
            S_READ: begin
                stall_req = 1'b1;
                state_nx  = S_SEND;
            end
            S_SEND: begin
                stall_req  = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) state_nx = (rem == REM_ONE) ? S_FIN : S_READ;
            end
            S_FIN: begin
                done     = 1'b1;
                rf_addr  = '0;
                state_nx = S_IDLE;
            end
            default: begin
                rf_addr  = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // Address pointer, remaining count and the presented word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            rem       <= '0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            if (start_ok && count != '0) begin
                ptr <= start_addr;
                rem <= count_clamped;
            end
            if (state == S_READ) begin
                dump_addr <= ptr;
                dump_data <= rf_data;
            end
            if (hs) begin
                rem <= rem - REM_ONE;
                if (rem != REM_ONE) ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_ONE;
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // Running XOR of accepted words; cleared by every accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          dump_sum <= '0;
        else if (start_ok) dump_sum <= '0;
        else if (hs)       dump_sum <= dump_sum ^ dump_data;
    end
`endif

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Testbench for reg_file_dump_reader: directed steps plus randomized dumps,
// checked against an array model of the register file.
module tb_reg_file_dump_reader;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          stall_ack = 1'b0;
    logic          dump_ready = 1'b0;
    logic          stall_req;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_data;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [W-1:0]  dump_data;
    logic          busy;
    logic          done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [W-1:0]  dump_sum;
`endif

    logic [W-1:0] mem [D];
    int tests = 0;
    int fails = 0;

    assign rf_data = mem[rf_addr];

    always #5 clk = ~clk;

    reg_file_dump_reader #(.REG_WIDTH(W), .REG_DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .count(count), .stall_req(stall_req), .stall_ack(stall_ack),
        .rf_addr(rf_addr), .rf_data(rf_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .busy(busy),
`ifdef REG_DUMP_CHECKSUM_EN
        .dump_sum(dump_sum),
`endif
        .done(done)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete dump. ack_d: negedge index at which stall_ack rises.
    // bp: cycles dump_ready is held low on the first presented word.
    task automatic run_dump(input int sa, input int cnt, input int ack_d,
                            input int bp, input bit rnd_ready, input bit rnd_ack);
        int n;
        int idx;
        int cyc;
        int first_v;
        int last_hs;
        int bp_left;
        bit prev_hs;
        bit got_done;
        bit saw_stall;
        int exp_a;
        logic [W-1:0] exp_sum;
        n = (cnt > D) ? D : cnt;
        idx = 0; first_v = -1; last_hs = -1; bp_left = bp;
        prev_hs = 0; got_done = 0; saw_stall = 0; exp_sum = '0;
        @(negedge clk);
        start = 1'b1; start_addr = AW'(sa); count = (AW+1)'(cnt);
        stall_ack = (ack_d == 0);
        dump_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 600) begin
            if (stall_req) saw_stall = 1;
            chk("busy_during_dump", busy, 1);
            if (ack_d > 0 && cyc <= ack_d && n > 0) begin
                chk("no_valid_before_ack", dump_valid, 0);
                chk("rf_addr_before_ack", rf_addr, sa);
                chk("stall_req_waiting", stall_req, 1);
            end
            if (prev_hs) chk("valid_gap_after_hs", dump_valid, 0);
            if (dump_valid) begin
                if (first_v < 0) first_v = cyc;
                chk("stall_req_with_valid", stall_req, 1);
                chk("word_within_count", idx < n, 1);
                exp_a = (sa + idx) % D;
                chk("dump_addr", dump_addr, exp_a);
                chk("dump_data", dump_data, mem[exp_a]);
            end
            if (done) begin
                got_done = 1;
                chk("done_stall_low", stall_req, 0);
                chk("done_valid_low", dump_valid, 0);
                chk("words_sent", idx, n);
                chk("done_timing", cyc, (n == 0) ? 1 : last_hs + 1);
`ifdef REG_DUMP_CHECKSUM_EN
                chk("dump_sum_at_done", dump_sum, exp_sum);
`endif
            end
            // drive inputs for the coming rising edge
            start = (ack_d >= 3 && cyc == 2);
            start_addr = AW'(sa + 7);
            count = 1;
            if (cyc >= ack_d) stall_ack = (rnd_ack && first_v >= 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dump_valid && bp_left > 0) begin
                dump_ready = 1'b0;
                bp_left--;
            end else begin
                dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_hs = dump_valid && dump_ready;
            if (prev_hs) begin
                exp_sum ^= mem[(sa + idx) % D];
                last_hs = cyc;
                idx++;
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        if (n == 0) begin
            chk("count0_no_stall", saw_stall, 0);
            chk("count0_no_valid", first_v, -1);
        end else if (bp == 0 || ack_d >= 0) begin
            chk("first_valid_latency", first_v, ((ack_d < 1) ? 1 : ack_d) + 2);
        end
        @(negedge clk);
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_stall_low", stall_req, 0);
        chk("idle_rf_addr", rf_addr, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("dump_sum_held", dump_sum, exp_sum);
`endif
    endtask

    initial begin
        int k;
        for (int i = 0; i < D; i++) mem[i] = $urandom;
        mem[5] = 32'h11111111;
        mem[6] = 32'h22222222;
        mem[7] = 32'h44444444;

        // reset state
        #12;
        chk("rst_stall_req", stall_req, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_addr", dump_addr, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-dump, while a word is held in SEND
        @(negedge clk);
        start = 1'b1; start_addr = 10; count = 5; stall_ack = 1'b1; dump_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!dump_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reached_send", dump_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_stall_req", stall_req, 0);
        chk("midrst_rf_addr", rf_addr, 0);
        chk("midrst_dump_valid", dump_valid, 0);
        chk("midrst_dump_addr", dump_addr, 0);
        chk("midrst_dump_data", dump_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("midrst_dump_sum", dump_sum, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        chk("post_rst_done", done, 0);

        // r5..r7 directed dump
        run_dump(5, 3, 0, 0, 0, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("sum_r5_r7", dump_sum, 32'h77777777);
`endif
        // backpressure: dump_ready low for 5 cycles on the first word
        run_dump(12, 2, 0, 5, 0, 0);
        // wrap
        run_dump(31, 2, 0, 0, 0, 0);
        run_dump(30, 4, 0, 0, 0, 0);
        // delayed stall_ack, with a start pulse while busy
        run_dump(9, 3, 4, 0, 0, 0);
        // count = 0
        run_dump(17, 0, 0, 0, 0, 0);
        // count above depth clamps to a full pass
        run_dump(3, 40, 1, 0, 0, 0);

        // randomized dumps
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < D; i++) mem[i] = $urandom;
            run_dump(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
